// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: computes {borrow, i_min - i_sub} one CHUNK-bit
// slice per clock, with a registered borrow between slices and valid/ready on both sides.
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_min,
    input  logic [WIDTH-1:0] i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_busy
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("serial_subtractor: CHUNK must divide WIDTH exactly");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH:0]   result_q, result_d;

    int               base;
    logic [CHUNK-1:0] a_s, b_s, d_s;
    logic             b_out;

    // Current slice: {b_out, d} = A[k] - B[k] - borrow_in
    always_comb begin
        base         = int'(cnt_q) * CHUNK;
        a_s          = a_q[base +: CHUNK];
        b_s          = b_q[base +: CHUNK];
        {b_out, d_s} = {1'b0, a_s} - {1'b0, b_s} - {{CHUNK{1'b0}}, borrow_q};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d      = i_min;
                    b_d      = i_sub;
                    diff_d   = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                diff_d[base +: CHUNK] = d_s;
                borrow_d              = b_out;
                cnt_d                 = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d = {b_out, diff_d};
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            result_q <= result_d;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_busy   = (state_q == RUN);
    assign o_valid  = (state_q == DONE);
    assign o_result = result_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: four instances (CHUNK = 8, 1, 4, 32) on WIDTH = 32,
// checked against a plain 33-bit arithmetic reference.
module tb_serial_subtractor;

    localparam int CHS [4] = '{8, 1, 4, 32};

    logic        clk;
    logic        rst_n;
    logic        vin  [4];
    logic        ordy [4];
    logic [31:0] mn   [4];
    logic [31:0] sb   [4];
    logic        ov   [4];
    logic        ird  [4];
    logic [32:0] res  [4];
    logic        busy [4];

    int n_tests = 0;
    int n_fail  = 0;

    serial_subtractor #(.WIDTH(32), .CHUNK(8)) u_c8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[0]), .o_ready(ordy[0]),
        .i_min(mn[0]), .i_sub(sb[0]), .o_valid(ov[0]), .i_ready(ird[0]),
        .o_result(res[0]), .o_busy(busy[0]));
    serial_subtractor #(.WIDTH(32), .CHUNK(1)) u_c1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[1]), .o_ready(ordy[1]),
        .i_min(mn[1]), .i_sub(sb[1]), .o_valid(ov[1]), .i_ready(ird[1]),
        .o_result(res[1]), .o_busy(busy[1]));
    serial_subtractor #(.WIDTH(32), .CHUNK(4)) u_c4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[2]), .o_ready(ordy[2]),
        .i_min(mn[2]), .i_sub(sb[2]), .o_valid(ov[2]), .i_ready(ird[2]),
        .o_result(res[2]), .o_busy(busy[2]));
    serial_subtractor #(.WIDTH(32), .CHUNK(32)) u_c32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[3]), .o_ready(ordy[3]),
        .i_min(mn[3]), .i_sub(sb[3]), .o_valid(ov[3]), .i_ready(ird[3]),
        .o_result(res[3]), .o_busy(busy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    // One transaction with i_ready held high; lat counts edges from accept to o_valid.
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, output logic [32:0] r,
                          output int lat, output int bc);
        @(negedge clk);
        vin[k] = 1'b1; mn[k] = a; sb[k] = b; ird[k] = 1'b1;
        @(negedge clk);
        vin[k] = 1'b0;
        lat = 0;
        bc  = int'(busy[k]);
        while (!ov[k] && lat < 200) begin
            if (scramble) begin
                mn[k] = $urandom; sb[k] = $urandom;
            end
            @(negedge clk);
            lat++;
            if (busy[k]) bc++;
        end
        r = res[k];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vin[k] = 1'b0; mn[k] = '0; sb[k] = '0; ird[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (ov[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d] got %b want 0", k, ov[k]); end
            n_tests++; if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d] got %b want 0", k, busy[k]); end
            n_tests++; if (ordy[k] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d] got %b want 1", k, ordy[k]); end
            n_tests++; if (res[k] !== 33'h0) begin n_fail++; $display("FAIL reset_result[%0d] got %h want 0", k, res[k]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (ordy[0] !== 1'b1 || ov[0] !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle got ready=%b valid=%b want 1/0", ordy[0], ov[0]);
        end
    endtask

    task automatic test_basic();
        logic [32:0] r;
        int lat, bc;
        run_op(0, 32'd100, 32'd58, 1'b0, r, lat, bc);
        n_tests++; if (r !== 33'h0_0000002A) begin n_fail++; $display("FAIL basic_result got %h want 00000002a", r); end
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency got %0d want 4", lat); end
        n_tests++; if (bc !== 4) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 4", bc); end
    endtask

    task automatic test_borrow();
        logic [31:0] av [3] = '{32'd5, 32'h0, 32'h12345678};
        logic [31:0] bv [3] = '{32'd7, 32'hFFFFFFFF, 32'h12345678};
        logic [32:0] ev [3] = '{{1'b1, 32'hFFFFFFFE}, {1'b1, 32'h00000001}, {1'b0, 32'h0}};
        logic [32:0] r;
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(0, av[i], bv[i], 1'b0, r, lat, bc);
            n_tests++; if (r !== ev[i]) begin n_fail++; $display("FAIL borrow_vec%0d got %h want %h", i, r, ev[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        logic [32:0] r0, r;
        int lat, bc, wait_cnt;
        a = $urandom; b = $urandom;
        @(negedge clk);
        vin[0] = 1'b1; mn[0] = a; sb[0] = b; ird[0] = 1'b0;
        @(negedge clk);
        vin[0] = 1'b0;
        wait_cnt = 0;
        while (!ov[0] && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        r0 = res[0];
        n_tests++; if (r0 !== model(a, b)) begin n_fail++; $display("FAIL bp_result got %h want %h", r0, model(a, b)); end
        for (int i = 0; i < 10; i++) begin
            vin[0] = 1'b1; mn[0] = $urandom; sb[0] = $urandom;
            @(negedge clk);
            n_tests++; if (ov[0] !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c%0d got %b want 1", i, ov[0]); end
            n_tests++; if (res[0] !== r0) begin n_fail++; $display("FAIL bp_hold_result c%0d got %h want %h", i, res[0], r0); end
            n_tests++; if (ordy[0] !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready c%0d got %b want 0", i, ordy[0]); end
        end
        vin[0] = 1'b0; ird[0] = 1'b1;
        @(negedge clk);
        n_tests++; if (ov[0] !== 1'b0 || ordy[0] !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", ov[0], ordy[0]);
        end
        n_tests++; if (res[0] !== r0) begin n_fail++; $display("FAIL bp_result_retained got %h want %h", res[0], r0); end
        a = $urandom; b = $urandom;
        run_op(0, a, b, 1'b0, r, lat, bc);
        n_tests++; if (r !== model(a, b)) begin n_fail++; $display("FAIL bp_next_op got %h want %h", r, model(a, b)); end
    endtask

    task automatic test_operand_change();
        logic [31:0] a, b;
        logic [32:0] r;
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom;
            run_op(0, a, b, 1'b1, r, lat, bc);
            n_tests++; if (r !== model(a, b)) begin n_fail++; $display("FAIL latch_result%0d got %h want %h", i, r, model(a, b)); end
            n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL latch_latency%0d got %0d want 4", i, lat); end
            @(negedge clk);
            n_tests++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL valid_pulse%0d got %b want 0", i, ov[0]); end
        end
    endtask

    task automatic test_reset_midrun();
        logic [32:0] r;
        int lat, bc;
        @(negedge clk);
        vin[0] = 1'b1; mn[0] = 32'hDEADBEEF; sb[0] = 32'h01234567; ird[0] = 1'b1;
        @(negedge clk);
        vin[0] = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL midrun_busy got %b want 1", busy[0]); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", ov[0]); end
        n_tests++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy[0]); end
        n_tests++; if (ordy[0] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b want 1", ordy[0]); end
        n_tests++; if (res[0] !== 33'h0) begin n_fail++; $display("FAIL rst_mid_result got %h want 0", res[0]); end
        #1 rst_n = 1'b1;
        run_op(0, 32'd9, 32'd4, 1'b0, r, lat, bc);
        n_tests++; if (r !== 33'h0_00000005) begin n_fail++; $display("FAIL rst_after_result got %h want 000000005", r); end
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL rst_after_latency got %0d want 4", lat); end
    endtask

    task automatic test_sweep();
        logic [31:0] a, b;
        logic [32:0] r;
        int lat, bc, nops;
        for (int k = 0; k < 4; k++) begin
            nops = (k == 0) ? 200 : 1000;
            for (int i = 0; i < nops; i++) begin
                case (i)
                    0:       begin a = 32'h0;        b = 32'h1;        end
                    1:       begin a = 32'h0;        b = 32'hFFFFFFFF; end
                    2:       begin a = 32'hFFFFFFFF; b = 32'h0;        end
                    3:       begin a = $urandom;     b = a;            end
                    default: begin a = $urandom;     b = $urandom;     end
                endcase
                run_op(k, a, b, 1'b0, r, lat, bc);
                n_tests++; if (r !== model(a, b)) begin
                    n_fail++; $display("FAIL sweep_c%0d_result a=%h b=%h got %h want %h", CHS[k], a, b, r, model(a, b));
                end
                n_tests++; if (lat !== 32 / CHS[k]) begin
                    n_fail++; $display("FAIL sweep_c%0d_latency got %0d want %0d", CHS[k], lat, 32 / CHS[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_backpressure();
        test_operand_change();
        test_reset_midrun();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
